// File: rtl/run_length_decoder.sv
// run_length_decoder
//
// Regenerates a 7-bit symbol stream from the run-length encoder's token
// stream. Tokens are buffered in a DEPTH-entry FIFO; a two-state machine
// (IDLE/EMIT) pops literals or count/symbol pairs and emits one symbol per
// clock.
//
// Handshake: validIn qualifies dataIn for one cycle and there is no
// backpressure (tokens that do not fit are dropped and flagged in overflow).
// validOut qualifies dataOut for one cycle and the consumer cannot stall it.
//
// Ports:
//   clock         in   single clock, rising edge
//   reset         in   synchronous active-high reset
//   dataIn[7:0]   in   token: bit7=1 count {1,N}, bit7=0 symbol {0,S}
//   validIn       in   dataIn valid this cycle
//   dataOut[6:0]  out  decoded symbol (holds last value when validOut=0)
//   validOut      out  dataOut valid this cycle
//   overflow      out  sticky: a token was dropped because the FIFO was full
//   protocolError out  sticky: malformed token sequence seen
//   debug_state   out  current FSM state (0 = IDLE, 1 = EMIT)
module run_length_decoder #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dataIn,
  input  logic       validIn,
  output logic [6:0] dataOut,
  output logic       validOut,
  output logic       overflow,
  output logic       protocolError,
  output logic       debug_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    sym_q, sym_d;
  logic [6:0]    rem_q, rem_d;
  logic [6:0]    data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
  logic          overflow_q, overflow_d;
  logic          perr_q, perr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    mem_q [DEPTH];

  logic [PW-1:0] occ;
  logic [PW-1:0] occ_after_pop;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rd_idx_nxt;
  logic [7:0]    head_tok;
  logic [7:0]    next_tok;
  logic          have_one;
  logic          have_two;
  logic [1:0]    pop_cnt;
  logic          wr_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occ        = wr_ptr_q - rd_ptr_q;
  assign rd_idx     = rd_ptr_q[AW-1:0];
  assign rd_idx_nxt = rd_idx + AW'(1);
  assign head_tok   = mem_q[rd_idx];
  assign next_tok   = mem_q[rd_idx_nxt];
  assign have_one   = (occ != '0);
  assign have_two   = (occ >= PW'(2));

  // Token decode and output generation.
  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    rem_d       = rem_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    perr_d      = perr_q;
    pop_cnt     = 2'd0;

    if (state_q == ST_EMIT) begin
      // Replay the latched symbol; nothing is popped until back in IDLE,
      // where the next token is picked up on the very next edge (gapless).
      valid_out_d = 1'b1;
      data_out_d  = sym_q;
      rem_d       = rem_q - 7'd1;
      if (rem_q == 7'd1) begin
        state_d = ST_IDLE;
      end
    end else if (have_one) begin
      if (!head_tok[7]) begin
        // Literal symbol.
        pop_cnt     = 2'd1;
        data_out_d  = head_tok[6:0];
        valid_out_d = 1'b1;
      end else if (have_two) begin
        if (next_tok[7]) begin
          // Count followed by count: drop the first one.
          pop_cnt = 2'd1;
          perr_d  = 1'b1;
        end else begin
          // Count/symbol pair consumed in one edge.
          pop_cnt = 2'd2;
          if (head_tok[6:0] == 7'd0) begin
            perr_d = 1'b1;
          end else begin
            valid_out_d = 1'b1;
            data_out_d  = next_tok[6:0];
            sym_d       = next_tok[6:0];
            if (head_tok[6:0] != 7'd1) begin
              rem_d   = head_tok[6:0] - 7'd1;
              state_d = ST_EMIT;
            end
          end
        end
      end
      // A lone count token waits for its symbol.
    end
  end

  // FIFO bookkeeping. A write is judged against occupancy after this
  // edge's pops, so a pop on a full FIFO makes room for the incoming token.
  always_comb begin
    occ_after_pop = occ - PW'(pop_cnt);
    wr_en         = validIn && (occ_after_pop < PW'(DEPTH));
    overflow_d    = overflow_q | (validIn & ~wr_en);
    rd_ptr_d      = rd_ptr_q + PW'(pop_cnt);
    wr_ptr_d      = wr_ptr_q + PW'(wr_en);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sym_q       <= '0;
      rem_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      perr_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      rem_q       <= rem_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      perr_q      <= perr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= dataIn;
    end
  end

  assign dataOut       = data_out_q;
  assign validOut      = valid_out_q;
  assign overflow      = overflow_q;
  assign protocolError = perr_q;
  assign debug_state   = state_q;

endmodule

// File: tb/tb_run_length_decoder.sv
`timescale 1ns/1ps
module tb_run_length_decoder;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DUT a: default depth; DUT b: depth 4 for the overflow scenario.
  logic [7:0] din_a, din_b;
  logic       vin_a, vin_b;
  logic [6:0] dout_a, dout_b;
  logic       vout_a, vout_b;
  logic       ovf_a, ovf_b;
  logic       perr_a, perr_b;
  logic       st_a, st_b;

  run_length_decoder #(.DEPTH(16)) dut_a (
    .clock(clock), .reset(reset), .dataIn(din_a), .validIn(vin_a),
    .dataOut(dout_a), .validOut(vout_a), .overflow(ovf_a),
    .protocolError(perr_a), .debug_state(st_a)
  );

  run_length_decoder #(.DEPTH(4)) dut_b (
    .clock(clock), .reset(reset), .dataIn(din_b), .validIn(vin_b),
    .dataOut(dout_b), .validOut(vout_b), .overflow(ovf_b),
    .protocolError(perr_b), .debug_state(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  logic [6:0] exp_b_q[$];
  int total = 0;
  int bad   = 0;
  logic gapless = 1'b0;
  logic prev_vout_a = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [6:0] e;
    if (vout_a) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_out: got %0h expected none at %0t", dout_a, $time);
      end else begin
        e = exp_q.pop_front();
        check("a_dataOut", 32'(dout_a), 32'(e));
      end
    end
    if (gapless && prev_vout_a && !vout_a && exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL a_bubble: got validOut 0 expected 1 at %0t", $time);
    end
    prev_vout_a = vout_a;
  end

  always @(negedge clock) begin
    logic [6:0] e;
    if (vout_b) begin
      if (exp_b_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_out: got %0h expected none at %0t", dout_b, $time);
      end else begin
        e = exp_b_q.pop_front();
        check("b_dataOut", 32'(dout_b), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] tok);
    din_a = tok;
    vin_a = 1'b1;
    @(posedge clock);
    #1;
    vin_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] tok);
    din_b = tok;
    vin_b = 1'b1;
    @(posedge clock);
    #1;
    vin_b = 1'b0;
  endtask

  task automatic push_a(input logic [6:0] sym, input int n);
    repeat (n) exp_q.push_back(sym);
  endtask

  task automatic push_b(input logic [6:0] sym, input int n);
    repeat (n) exp_b_q.push_back(sym);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && exp_b_q.size() == 0) break;
      @(negedge clock);
    end
    total++;
    if (exp_q.size() != 0 || exp_b_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d/%0d pending expected 0", name, exp_q.size(), exp_b_q.size());
      exp_q.delete();
      exp_b_q.delete();
    end
    // Extra cycles so any stray output is seen by the monitors.
    repeat (4) @(negedge clock);
    idle(1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    @(negedge clock);
    check("rst_dataOut", 32'(dout_a), 32'h0);
    check("rst_validOut", 32'(vout_a), 32'h0);
    check("rst_overflow", 32'(ovf_a), 32'h0);
    check("rst_protocolError", 32'(perr_a), 32'h0);
    check("rst_state", 32'(st_a), 32'h0);
    check("rst_b_overflow", 32'(ovf_b), 32'h0);
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    din_a = '0; vin_a = 1'b0;
    din_b = '0; vin_b = 1'b0;
    idle(3);
    do_reset();

    // Literals, 2-cycle latency, consecutive outputs.
    push_a(7'h37, 1);
    push_a(7'h1C, 1);
    send_a(8'h37);
    send_a(8'h1C);
    @(negedge clock);
    check("lit_latency_valid", 32'(vout_a), 32'h1);
    check("lit_latency_data", 32'(dout_a), 32'h37);
    @(negedge clock);
    check("lit_second_valid", 32'(vout_a), 32'h1);
    check("lit_second_data", 32'(dout_a), 32'h1C);
    wait_drain("literals", 20);
    idle($urandom_range(1, 4));

    // Run of 3 followed by literals, no gaps.
    gapless = 1'b1;
    send_a(8'h83);
    push_a(7'h4B, 3);
    send_a(8'h4B);
    push_a(7'h37, 1);
    send_a(8'h37);
    push_a(7'h1C, 1);
    send_a(8'h1C);
    wait_drain("run3", 30);
    gapless = 1'b0;
    check("run3_perr", 32'(perr_a), 32'h0);
    idle($urandom_range(1, 4));

    // Long run of 270, split 127 + 127 + 16.
    gapless = 1'b1;
    send_a(8'hFF);
    push_a(7'h08, 127);
    send_a(8'h08);
    send_a(8'hFF);
    push_a(7'h08, 127);
    send_a(8'h08);
    send_a(8'h90);
    push_a(7'h08, 16);
    send_a(8'h08);
    wait_drain("run270", 400);
    gapless = 1'b0;
    check("run270_overflow", 32'(ovf_a), 32'h0);
    check("run270_perr", 32'(perr_a), 32'h0);

    // Zero-length run: no output, error flagged.
    do_reset();
    send_a(8'h80);
    send_a(8'h05);
    wait_drain("zero_run", 20);
    check("zero_run_perr", 32'(perr_a), 32'h1);
    check("zero_run_state", 32'(st_a), 32'h0);

    // Count followed by count: first dropped, 0x11 x4.
    do_reset();
    send_a(8'h83);
    send_a(8'h84);
    push_a(7'h11, 4);
    send_a(8'h11);
    wait_drain("double_count", 30);
    check("double_count_perr", 32'(perr_a), 32'h1);

    // Overflow on the depth-4 instance: only 4 of 6 literals fit.
    do_reset();
    send_b(8'hFF);
    push_b(7'h2A, 127);
    send_b(8'h2A);
    push_b(7'h01, 1);
    push_b(7'h02, 1);
    push_b(7'h03, 1);
    push_b(7'h04, 1);
    for (int i = 1; i <= 6; i++) send_b(8'(i));
    wait_drain("overflow", 200);
    check("overflow_flag", 32'(ovf_b), 32'h1);
    check("overflow_perr", 32'(perr_b), 32'h0);

    // Reset mid-run: error flag set first, queued literals must be flushed.
    do_reset();
    send_a(8'h80);
    send_a(8'h05);
    send_a(8'hFF);
    push_a(7'h2A, 127);
    send_a(8'h2A);
    send_a(8'h11);
    send_a(8'h22);
    idle(40);
    check("midrun_perr_before", 32'(perr_a), 32'h1);
    check("midrun_state_before", 32'(st_a), 32'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("midrun_validOut", 32'(vout_a), 32'h0);
    check("midrun_perr_after", 32'(perr_a), 32'h0);
    check("midrun_overflow_after", 32'(ovf_a), 32'h0);
    check("midrun_state_after", 32'(st_a), 32'h0);
    idle(6);
    push_a(7'h55, 1);
    send_a(8'h55);
    @(posedge clock);
    @(negedge clock);
    check("post_reset_lit_valid", 32'(vout_a), 32'h1);
    check("post_reset_lit_data", 32'(dout_a), 32'h55);
    wait_drain("post_reset", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
